// File: rtl/board_row_fetcher.sv
// Fetches one board row per block-row boundary during hblank and holds it
// in a registered buffer that color_mapper indexes by column.
module board_row_fetcher #(
    parameter int unsigned SQUARE_SIZE = 21,
    parameter int unsigned BOARD_W     = 10,
    parameter int unsigned BOARD_H     = 20,
    parameter int unsigned CELL_W      = 12,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned V_TOTAL     = 525
) (
    input  logic                      Clk,
    input  logic                      reset,
    input  logic                      line_end,
    input  logic [9:0]                DrawY,
    output logic                      mem_rd_en,
    output logic [7:0]                mem_addr,
    input  logic [CELL_W-1:0]         mem_rd_data,
    output logic [BOARD_W*CELL_W-1:0] row_cells,
    output logic                      row_valid,
    output logic [4:0]                cur_row,
    output logic                      busy,
    output logic                      overrun
);

    localparam int unsigned CW = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;
    localparam int unsigned YW = (SQUARE_SIZE > 1) ? $clog2(SQUARE_SIZE) : 1;
    localparam int unsigned DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int unsigned RW = 5;
    localparam logic [9:0] LAST_LINE   = 10'(V_TOTAL - 1);
    localparam logic [9:0] BOARD_LINES = 10'(BOARD_H * SQUARE_SIZE);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, COMMIT} state_t;

    state_t                    state;
    logic [YW-1:0]             y_in_row;
    logic [RW-1:0]             next_row;
    logic [CW-1:0]             col;
    logic [DW-1:0]             drain_cnt;
    logic [RW-1:0]             fetch_row;
    logic                      pipe_v   [RD_LAT];
    logic [CW-1:0]             pipe_col [RD_LAT];
    logic [BOARD_W*CELL_W-1:0] shadow;

    logic                      fetch_trig;
    logic                      clear_trig;
    logic [RW-1:0]             trig_row;

    // Triggers are suppressed in vertical blank; only the frame-wrap line fires there.
    always_comb begin
        fetch_trig = 1'b0;
        clear_trig = 1'b0;
        trig_row   = '0;
        if (line_end) begin
            if (DrawY == LAST_LINE) begin
                fetch_trig = 1'b1;
            end else if (y_in_row == YW'(SQUARE_SIZE - 1) && DrawY < BOARD_LINES) begin
                if (next_row < RW'(BOARD_H)) begin
                    fetch_trig = 1'b1;
                    trig_row   = next_row;
                end else begin
                    clear_trig = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            y_in_row <= '0;
            next_row <= '0;
        end else if (line_end) begin
            if (DrawY == LAST_LINE) begin
                y_in_row <= '0;
                next_row <= RW'(1);
            end else if (y_in_row == YW'(SQUARE_SIZE - 1)) begin
                y_in_row <= '0;
                if (next_row < RW'(BOARD_H))
                    next_row <= next_row + RW'(1);
            end else begin
                y_in_row <= y_in_row + YW'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state     <= IDLE;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            row_cells <= '0;
            row_valid <= 1'b0;
            cur_row   <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            col       <= '0;
            drain_cnt <= '0;
            fetch_row <= '0;
            shadow    <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_v[i]   <= 1'b0;
                pipe_col[i] <= '0;
            end
        end else begin
            // Column tag travels alongside the RAM latency so data lands in its own slot.
            pipe_v[0]   <= mem_rd_en;
            pipe_col[0] <= col;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_col[i] <= pipe_col[i-1];
            end
            for (int unsigned c = 0; c < BOARD_W; c++) begin
                if (pipe_v[RD_LAT-1] && pipe_col[RD_LAT-1] == CW'(c))
                    shadow[c*CELL_W +: CELL_W] <= mem_rd_data;
            end

            if (fetch_trig && state != IDLE)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (fetch_trig) begin
                        state     <= READ;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= 8'(trig_row * BOARD_W);
                        col       <= '0;
                        fetch_row <= trig_row;
                    end
                end
                READ: begin
                    if (col == CW'(BOARD_W - 1)) begin
                        state     <= DRAIN;
                        mem_rd_en <= 1'b0;
                        mem_addr  <= '0;
                        drain_cnt <= '0;
                    end else begin
                        col      <= col + CW'(1);
                        mem_addr <= mem_addr + 8'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DW'(RD_LAT - 1))
                        state <= COMMIT;
                    else
                        drain_cnt <= drain_cnt + DW'(1);
                end
                COMMIT: begin
                    row_cells <= shadow;
                    row_valid <= 1'b1;
                    cur_row   <= fetch_row;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (clear_trig)
                row_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_board_row_fetcher.sv
// Bench for board_row_fetcher: three read-latency builds share one stimulus
// stream and are checked every cycle against a timing/arithmetic model.
module tb_board_row_fetcher;

    logic         Clk;
    logic         reset;
    logic         line_end;
    logic [9:0]   DrawY;

    logic         rd_en_w  [3];
    logic [7:0]   addr_w   [3];
    logic [11:0]  rdata_w  [3];
    logic [119:0] cells_w  [3];
    logic         valid_w  [3];
    logic [4:0]   row_w    [3];
    logic         busy_w   [3];
    logic         ovr_w    [3];

    logic [11:0]  mem [200];

    int total;
    int bad;
    int n_edge;
    int bursts;
    bit prev_rd;

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : 4;
    endfunction

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    for (genvar g = 0; g < 3; g++) begin : lat
        logic [11:0] rp [4];

        always @(posedge Clk) begin
            for (int i = 3; i > 0; i--) rp[i] <= rp[i-1];
            rp[0] <= (rd_en_w[g] && addr_w[g] < 8'd200) ? mem[addr_w[g]] : 12'hBAD;
        end
        assign rdata_w[g] = rp[lat_of(g)-1];

        board_row_fetcher #(.RD_LAT(lat_of(g))) dut (
            .Clk         (Clk),
            .reset       (reset),
            .line_end    (line_end),
            .DrawY       (DrawY),
            .mem_rd_en   (rd_en_w[g]),
            .mem_addr    (addr_w[g]),
            .mem_rd_data (rdata_w[g]),
            .row_cells   (cells_w[g]),
            .row_valid   (valid_w[g]),
            .cur_row     (row_w[g]),
            .busy        (busy_w[g]),
            .overrun     (ovr_w[g])
        );
    end

    task automatic check(input string name, input int g,
                         input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s lat=%0d t=%0t got=%0h want=%0h", name, lat_of(g), $time, got, want);
        end
    endtask

    // Model: a fetch of row r started at edge T reads addresses r*10+k after
    // edges T+k (k<10) and publishes the RAM row at edge T+10+L+1.
    bit           m_act  [3];
    int           m_t    [3];
    int           m_row  [3];
    logic [119:0] m_snap [3];
    logic         e_rd   [3];
    logic [7:0]   e_addr [3];
    logic         e_val  [3];
    logic [4:0]   e_row  [3];
    logic [119:0] e_cell [3];
    logic         e_busy [3];
    logic         e_ovr  [3];

    always @(posedge Clk) begin
        bit fetch, clr, start;
        int dy, trow, k;
        n_edge++;
        fetch = 0; clr = 0; trow = 0;
        dy = int'(DrawY);
        if (line_end) begin
            if (dy == 524) begin
                fetch = 1;
            end else if (dy < 420 && (dy + 1) % 21 == 0) begin
                if ((dy + 1) / 21 < 20) begin
                    fetch = 1;
                    trow = (dy + 1) / 21;
                end else begin
                    clr = 1;
                end
            end
        end
        for (int g = 0; g < 3; g++) begin
            if (!reset) begin
                m_act[g] = 0; e_rd[g] = 0; e_addr[g] = '0; e_val[g] = 0;
                e_row[g] = '0; e_cell[g] = '0; e_busy[g] = 0; e_ovr[g] = 0;
            end else begin
                if (fetch && m_act[g]) e_ovr[g] = 1;
                start = fetch && !m_act[g];
                if (m_act[g] && n_edge - m_t[g] == 11 + lat_of(g)) begin
                    e_cell[g] = m_snap[g];
                    e_val[g]  = 1;
                    e_row[g]  = 5'(m_row[g]);
                    m_act[g]  = 0;
                end
                if (start) begin
                    m_act[g] = 1;
                    m_t[g]   = n_edge;
                    m_row[g] = trow;
                    for (int c = 0; c < 10; c++) m_snap[g][c*12 +: 12] = mem[trow*10 + c];
                end
                if (clr) e_val[g] = 0;
                if (m_act[g]) begin
                    k = n_edge - m_t[g];
                    e_busy[g] = 1;
                    e_rd[g]   = (k < 10);
                    e_addr[g] = (k < 10) ? 8'(m_row[g]*10 + k) : 8'd0;
                end else begin
                    e_busy[g] = 0; e_rd[g] = 0; e_addr[g] = '0;
                end
            end
        end
    end

    always @(negedge Clk) begin
        for (int g = 0; g < 3; g++) begin
            check("rd_en",     g, 128'(rd_en_w[g]), 128'(e_rd[g]));
            check("mem_addr",  g, 128'(addr_w[g]),  128'(e_addr[g]));
            check("row_valid", g, 128'(valid_w[g]), 128'(e_val[g]));
            check("cur_row",   g, 128'(row_w[g]),   128'(e_row[g]));
            check("row_cells", g, 128'(cells_w[g]), 128'(e_cell[g]));
            check("busy",      g, 128'(busy_w[g]),  128'(e_busy[g]));
            check("overrun",   g, 128'(ovr_w[g]),   128'(e_ovr[g]));
        end
        if (rd_en_w[1] && !prev_rd) bursts++;
        prev_rd = rd_en_w[1];
    end

    task automatic line_pulse(input int y, input int gap);
        @(negedge Clk);
        line_end = 1'b1;
        DrawY    = 10'(y);
        @(negedge Clk);
        line_end = 1'b0;
        repeat (gap) @(negedge Clk);
    endtask

    initial begin
        int b0;
        reset = 1'b0; line_end = 1'b0; DrawY = '0;
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++)
                mem[r*10 + c] = (r == 0) ? 12'(256 + c) : 12'(r*16 + c);

        // reset held low while line_end pulses
        @(negedge Clk); line_end = 1'b1; DrawY = 10'd524;
        @(negedge Clk); line_end = 1'b0;
        @(negedge Clk); line_end = 1'b1; DrawY = 10'd20;
        @(negedge Clk); line_end = 1'b0;
        check("rst_rd_en", 1, 128'(rd_en_w[1]), 128'd0);
        check("rst_valid", 1, 128'(valid_w[1]), 128'd0);
        check("rst_cells", 1, 128'(cells_w[1]), 128'd0);
        reset = 1'b1;
        repeat (2) @(negedge Clk);

        // row 0 fetch: addresses and commit latency per build
        b0 = bursts;
        @(negedge Clk); line_end = 1'b1; DrawY = 10'd524;
        @(negedge Clk); line_end = 1'b0;
        check("first_addr", 1, 128'(addr_w[1]), 128'd0);
        check("first_rd",   1, 128'(rd_en_w[1]), 128'd1);
        for (int k = 1; k <= 17; k++) begin
            if (k == 2) check("second_addr", 1, 128'(addr_w[1]), 128'd1);
            for (int g = 0; g < 3; g++)
                check("commit_time", g, 128'(valid_w[g]), 128'(k >= 12 + lat_of(g)));
            @(negedge Clk);
        end
        for (int g = 0; g < 3; g++) begin
            check("row0_col3", g, 128'(cells_w[g][3*12 +: 12]), 128'h103);
            check("row0_col9", g, 128'(cells_w[g][9*12 +: 12]), 128'h109);
        end

        // full frame sweep
        for (int d = 0; d < 524; d++) begin
            line_pulse(d, 18);
            if (d == 418) check("valid_418", 1, 128'(valid_w[1]), 128'd1);
            if (d == 419) check("valid_419", 1, 128'(valid_w[1]), 128'd0);
        end
        check("burst_count", 1, 128'(bursts - b0), 128'd20);
        for (int g = 0; g < 3; g++) begin
            check("row19_col5", g, 128'(cells_w[g][5*12 +: 12]), 128'h135);
            check("row19_id",   g, 128'(row_w[g]), 128'd19);
            check("sweep_ovr",  g, 128'(ovr_w[g]), 128'd0);
        end

        // second trigger five cycles into a fetch
        for (int c = 0; c < 10; c++) mem[c] = 12'(12'hA00 + c);
        b0 = bursts;
        @(negedge Clk); line_end = 1'b1; DrawY = 10'd524;
        @(negedge Clk); line_end = 1'b0;
        repeat (4) @(negedge Clk);
        line_end = 1'b1; DrawY = 10'd524;
        @(negedge Clk); line_end = 1'b0;
        for (int g = 0; g < 3; g++) check("ovr_set", g, 128'(ovr_w[g]), 128'd1);
        repeat (14) @(negedge Clk);
        for (int g = 0; g < 3; g++) check("ovr_col7", g, 128'(cells_w[g][7*12 +: 12]), 128'hA07);
        check("ovr_bursts", 1, 128'(bursts - b0), 128'd1);

        // reset during READ at column 4
        @(negedge Clk); line_end = 1'b1; DrawY = 10'd524;
        @(negedge Clk); line_end = 1'b0;
        repeat (4) @(negedge Clk);
        check("abort_addr", 1, 128'(addr_w[1]), 128'd4);
        reset = 1'b0;
        @(negedge Clk);
        check("abort_rd",  1, 128'(rd_en_w[1]), 128'd0);
        check("abort_val", 1, 128'(valid_w[1]), 128'd0);
        reset = 1'b1;
        repeat (8) @(negedge Clk);
        for (int g = 0; g < 3; g++) check("abort_cells", g, 128'(cells_w[g]), 128'd0);

        // pattern rows 1 and 2 after a fresh frame start
        line_pulse(524, 18);
        for (int d = 0; d <= 41; d++) line_pulse(d, 18);
        for (int g = 0; g < 3; g++) begin
            check("row2_id",   g, 128'(row_w[g]), 128'd2);
            check("row2_col4", g, 128'(cells_w[g][4*12 +: 12]), 128'h24);
            check("row2_val",  g, 128'(valid_w[g]), 128'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
